shared_buffer: RTL and testbench

//  Shared-memory packet-cell buffer for a switch datapath: one RAM pool serves 2**N logical

---
 rtl/shared_buffer_pkg.sv | 17 +
 rtl/shared_buffer_if.sv | 26 ++
 rtl/sb_free_list.sv | 70 +++++++
 rtl/shared_buffer.sv | 140 ++++++++++++++
 tb/tb_shared_buffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/shared_buffer_pkg.sv
// Shared packet-cell buffer: sizes and common types.
// Optional feature macro used by this block: SB_DROP_CNT_EN (dropped-write counter).
package shared_buffer_pkg;

  localparam int unsigned N     = 4;          // data and queue-index width
  localparam int unsigned AW    = 4;          // cell-address width
  localparam int unsigned NQ    = 1 << N;     // number of logical queues
  localparam int unsigned DEPTH = 1 << AW;    // cells in the pool
  localparam int unsigned CW    = AW + 1;     // cell-count width, holds 0..DEPTH
  localparam int unsigned DCW   = 16;         // dropped-write counter width

  typedef logic [AW-1:0] cell_t;
  typedef logic [N-1:0]  qidx_t;
  typedef logic [N-1:0]  data_t;
  typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/shared_buffer_if.sv
// Enqueue/dequeue bus of the shared buffer.
interface shared_buffer_if;
  import shared_buffer_pkg::*;

  logic  wr_req;
  logic  rd_req;
  qidx_t ip;
  data_t idata;
  qidx_t op;
  data_t odata;
  logic  ovalid;
  logic  full;

  // Requester side (ingress classifier / scheduler / bench)
  modport master (
    output wr_req, rd_req, ip, idata,
    input  op, odata, ovalid, full
  );

  // Buffer side
  modport slave (
    input  wr_req, rd_req, ip, idata,
    output op, odata, ovalid, full
  );

endinterface

// File: rtl/sb_free_list.sv
// Linked list of free cells: pop from head, push onto tail.
// A pop and a push in the same cycle are both honoured; pop uses the old head and
// push the old tail, so the same cell is never handed out while being returned.
module sb_free_list
  import shared_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  pop,
  input  logic  push,
  input  cell_t push_cell,
  output cell_t pop_cell_c,
  output logic  empty
);

  cell_t link_q [DEPTH];
  cell_t link_d [DEPTH];
  cell_t head_q, head_d;
  cell_t tail_q, tail_d;
  cnt_t  cnt_q,  cnt_d;
  logic  empty_q, empty_d;

  assign pop_cell_c = head_q;
  assign empty      = empty_q;

  // Next free-list state from this cycle's pop/push
  always_comb begin
    link_d = link_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    if (pop) begin
      head_d = link_q[head_q];
    end

    if (push) begin
      // Empty list, or last cell being popped now: returned cell becomes the head
      if ((cnt_q == '0) || (pop && (cnt_q == CW'(1)))) begin
        head_d = push_cell;
      end else begin
        link_d[tail_q] = push_cell;
      end
      tail_d = push_cell;
    end

    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    empty_d = (cnt_d == '0);
  end

  // Free-list registers; reset links every cell in address order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        link_q[i] <= AW'(i + 1);
      end
      head_q  <= '0;
      tail_q  <= AW'(DEPTH - 1);
      cnt_q   <= CW'(DEPTH);
      empty_q <= 1'b0;
    end else begin
      link_q  <= link_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/shared_buffer.sv
// Shared-memory packet-cell buffer: NQ linked-list FIFOs over one cell pool.
// Optional SB_DROP_CNT_EN: adds drop_cnt, a saturating count of writes refused while full.
module shared_buffer
  import shared_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  shared_buffer_if.slave bus
`ifdef SB_DROP_CNT_EN
  ,
  output logic [DCW-1:0] drop_cnt
`endif
);

  data_t data_q [DEPTH];
  data_t data_d [DEPTH];
  cell_t next_q [DEPTH];
  cell_t next_d [DEPTH];
  cell_t head_q [NQ];
  cell_t head_d [NQ];
  cell_t tail_q [NQ];
  cell_t tail_d [NQ];
  cnt_t  cnt_q  [NQ];
  cnt_t  cnt_d  [NQ];

  qidx_t op_q, op_d;
  data_t odata_q, odata_d;
  logic  ovalid_q, ovalid_d;

  logic  fl_empty;
  cell_t alloc_cell;
  cell_t rd_cell;
  cnt_t  q_cnt;
  logic  wr_en;
  logic  rd_en;

  // Full/empty are judged on pre-cycle state only
  assign q_cnt   = cnt_q[bus.ip];
  assign rd_cell = head_q[bus.ip];
  assign wr_en   = bus.wr_req && !fl_empty;
  assign rd_en   = bus.rd_req && (q_cnt != '0);

  sb_free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop        (wr_en),
    .push       (rd_en),
    .push_cell  (rd_cell),
    .pop_cell_c (alloc_cell),
    .empty      (fl_empty)
  );

  assign bus.op     = op_q;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.full   = fl_empty;

  // Queue bookkeeping for a dequeue and/or enqueue on queue ip
  always_comb begin
    data_d   = data_q;
    next_d   = next_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;

    if (rd_en) begin
      odata_d             = data_q[rd_cell];
      op_d                = bus.ip;
      ovalid_d            = 1'b1;
      head_d[bus.ip]      = next_q[rd_cell];
    end

    if (wr_en) begin
      data_d[alloc_cell] = bus.idata;
      // Queue empty before, or its only cell leaves now: new cell is the head
      if ((q_cnt == '0) || (rd_en && (q_cnt == CW'(1)))) begin
        head_d[bus.ip] = alloc_cell;
      end else begin
        next_d[tail_q[bus.ip]] = alloc_cell;
      end
      tail_d[bus.ip] = alloc_cell;
    end

    cnt_d[bus.ip] = q_cnt + CW'(wr_en) - CW'(rd_en);
  end

  // Cell RAMs, queue registers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        next_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NQ; j++) begin
        head_q[j] <= '0;
        tail_q[j] <= '0;
        cnt_q[j]  <= '0;
      end
      op_q     <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      next_q   <= next_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

`ifdef SB_DROP_CNT_EN
  logic [DCW-1:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  // Count writes refused for lack of a free cell, saturating
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.wr_req && fl_empty && (drop_cnt_q != {DCW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DCW'(1);
    end
  end

  // Drop counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_shared_buffer.sv
// Self-checking bench for shared_buffer (directed vectors, small queue model for read data).
module tb_shared_buffer;

  logic clk;
  logic rst;

  shared_buffer_if bus ();

`ifdef SB_DROP_CNT_EN
  logic [15:0] drop_cnt;
  int          exp_drops;
`endif

  shared_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic [3:0] mq [16][$];
  logic [3:0] last_d;
  logic [3:0] last_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_used();
    int s;
    s = 0;
    for (int k = 0; k < 16; k++) s += mq[k].size();
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 16; k++) mq[k].delete();
    last_d = '0;
    last_q = '0;
  endfunction

  // One clock of optional write+read on queue q, then compare outputs
  task automatic step(input string tag, input bit wr, input bit rd, input int q, input int d);
    bit pre_full;
    bit exp_v;
    pre_full = (model_used() == 16);
    exp_v    = rd && (mq[q].size() != 0);
    bus.wr_req = wr;
    bus.rd_req = rd;
    bus.ip     = 4'(q);
    bus.idata  = 4'(d);
    @(posedge clk);
    #1;
    if (exp_v) begin
      last_d = mq[q].pop_front();
      last_q = 4'(q);
    end
    if (wr && !pre_full) mq[q].push_back(4'(d));
`ifdef SB_DROP_CNT_EN
    if (wr && pre_full) exp_drops++;
`endif
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    check_eq({tag, ".ovalid"}, 32'(bus.ovalid), 32'(exp_v));
    check_eq({tag, ".odata"},  32'(bus.odata),  32'(last_d));
    check_eq({tag, ".op"},     32'(bus.op),     32'(last_q));
    check_eq({tag, ".full"},   32'(bus.full),   32'(model_used() == 16));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
`ifdef SB_DROP_CNT_EN
    exp_drops  = 0;
`endif
    model_clear();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.ip     = '0;
    bus.idata  = '0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state, read of an empty queue
    check_eq("rst.op",     32'(bus.op),     32'd0);
    check_eq("rst.odata",  32'(bus.odata),  32'd0);
    check_eq("rst.ovalid", 32'(bus.ovalid), 32'd0);
    check_eq("rst.full",   32'(bus.full),   32'd0);
`ifdef SB_DROP_CNT_EN
    check_eq("rst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    step("t1.rd5", 0, 1, 5, 0);

    // 2: two writes to q0, reads of other queues stay idle
    step("t2.wr13", 1, 0, 0, 13);
    step("t2.wr2",  1, 0, 0, 2);
    step("t2.rd1",  0, 1, 1, 0);
    step("t2.rd4",  0, 1, 4, 0);
    check_eq("t2.hold_odata", 32'(bus.odata), 32'd0);

    // 3: drain q0 in order, third read finds it empty and outputs hold
    step("t3.rd_a", 0, 1, 0, 0);
    check_eq("t3.first", 32'(bus.odata), 32'd13);
    step("t3.rd_b", 0, 1, 0, 0);
    check_eq("t3.second", 32'(bus.odata), 32'd2);
    step("t3.rd_c", 0, 1, 0, 0);
    check_eq("t3.hold", 32'(bus.odata), 32'd2);

    // 4: fill the pool across q3 and q7, extra write dropped
    for (int i = 0; i < 16; i++) begin
      step("t4.fill", 1, 0, (i % 2 == 0) ? 3 : 7, (i * 3 + 5) & 15);
    end
    check_eq("t4.full", 32'(bus.full), 32'd1);
    step("t4.drop", 1, 0, 3, 9);

    // 5: full pool, write+read same cycle: read served, write dropped
    step("t5.wr_rd_full", 1, 1, 3, 10);
    check_eq("t5.first_q3", 32'(bus.odata), 32'd5);
    check_eq("t5.not_full", 32'(bus.full), 32'd0);
    // single free cell popped and pushed in one cycle
    step("t5.wr_rd_one", 1, 1, 3, 12);
    check_eq("t5.second_q3", 32'(bus.odata), 32'd11);
    check_eq("t5.still_free", 32'(bus.full), 32'd0);
    step("t5.wr_q2", 1, 0, 2, 6);
    check_eq("t5.full_again", 32'(bus.full), 32'd1);
`ifdef SB_DROP_CNT_EN
    check_eq("t5.drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

    // drain all queues in per-queue order, then confirm each is empty
    for (int i = 0; i < 7; i++) step("t4.drain_q3", 0, 1, 3, 0);
    check_eq("t4.q3_last", 32'(bus.odata), 32'd12);
    step("t4.q3_empty", 0, 1, 3, 0);
    for (int i = 0; i < 8; i++) step("t4.drain_q7", 0, 1, 7, 0);
    check_eq("t4.q7_last", 32'(bus.odata), 32'd2);
    step("t4.q7_empty", 0, 1, 7, 0);
    step("t4.drain_q2", 0, 1, 2, 0);
    check_eq("t4.q2_val", 32'(bus.odata), 32'd6);
    step("t4.q2_empty", 0, 1, 2, 0);

    // same-queue write+read with one queued cell, and with an empty queue
    step("t5.wr_q5", 1, 0, 5, 4);
    step("t5.wr_rd_q5", 1, 1, 5, 11);
    check_eq("t5.q5_a", 32'(bus.odata), 32'd4);
    step("t5.rd_q5", 0, 1, 5, 0);
    check_eq("t5.q5_b", 32'(bus.odata), 32'd11);
    step("t5.wr_rd_q6_empty", 1, 1, 6, 14);
    step("t5.rd_q6", 0, 1, 6, 0);
    check_eq("t5.q6", 32'(bus.odata), 32'd14);

    // 6: asynchronous reset with cells queued
    step("t6.wr_q1a", 1, 0, 1, 3);
    step("t6.wr_q9",  1, 0, 9, 7);
    step("t6.wr_q1b", 1, 0, 1, 8);
    step("t6.rd_q1",  0, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_eq("t6.async.ovalid", 32'(bus.ovalid), 32'd0);
    check_eq("t6.async.odata",  32'(bus.odata),  32'd0);
    check_eq("t6.async.full",   32'(bus.full),   32'd0);
`ifdef SB_DROP_CNT_EN
    exp_drops = 0;
    check_eq("t6.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t6.rd_q1", 0, 1, 1, 0);
    step("t6.rd_q9", 0, 1, 9, 0);
    // exactly 16 free cells after reset
    for (int i = 0; i < 16; i++) step("t6.fill", 1, 0, i, 15 - i);
    check_eq("t6.full", 32'(bus.full), 32'd1);
    step("t6.rd_q0", 0, 1, 0, 0);
    check_eq("t6.q0", 32'(bus.odata), 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
